// File: rtl/io_memory_loader_pkg.sv
// Shared opcodes, response bytes and FSM state encoding for the memory loader.
package io_memory_loader_pkg;

  localparam logic [7:0] OP_LOAD_INSTR = 8'h01;
  localparam logic [7:0] OP_LOAD_DATA  = 8'h02;
  localparam logic [7:0] OP_DUMP       = 8'h03;
  localparam logic [7:0] OP_START      = 8'h04;

  localparam logic [7:0] DEFAULT_ACK_BYTE = 8'hAA;
  localparam logic [7:0] DEFAULT_ERR_BYTE = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARG,
    ST_WORD,
    ST_WRITE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_TX_WORD,
    ST_ACK
  } state_t;

endpackage

// File: rtl/io_memory_loader_byte_word_assembler.sv
// Collects four bytes, least significant first, into a 32-bit word.
// The completed word and done are presented in the cycle the fourth byte
// arrives, so the caller can capture them without an extra cycle.
module io_memory_loader_byte_word_assembler (
  input  logic        clk,
  input  logic        rstn,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        done
);

  logic [23:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;

  assign word = {byte_in, shift_q};
  assign done = byte_valid && (cnt_q == 2'd3);

  // Shift in each new byte at the top so the first byte ends up lowest.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clear) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (byte_valid) begin
      shift_d = {byte_in, shift_q[23:8]};
      cnt_d   = cnt_q + 2'd1;
    end
  end

  // Byte counter and partial-word register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/io_memory_loader.sv
// Host-side loader: turns UART byte commands into instruction/data RAM
// writes, a sticky core start, and data RAM dumps streamed back over UART.
module io_memory_loader
  import io_memory_loader_pkg::*;
#(
  parameter int unsigned ADDR_W   = 14,
  parameter logic [7:0]  ACK_BYTE = DEFAULT_ACK_BYTE,
  parameter logic [7:0]  ERR_BYTE = DEFAULT_ERR_BYTE
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        wr_en_instr,
  output logic [31:0] data_in_instr,
  output logic [31:0] addr_in_instr,
  output logic        memwrite_io,
  output logic [31:0] write_data_io,
  output logic [31:0] addr_io,
  output logic        memread_io,
  input  logic [31:0] data_from_memory_io,
  input  logic        data_ready_io,
  input  logic        core_end,
  output logic        core_start,
  output logic        error
);

  localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;

  state_t              state_q, state_d;
  logic [7:0]          cmd_q, cmd_d;
  logic                arg_idx_q, arg_idx_d;
  logic [ADDR_W+1:0]   base_q, base_d;
  logic [31:0]         rem_q, rem_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         data_q, data_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [7:0]          resp_q, resp_d;
  logic                tx_start_q, tx_start_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                error_q, error_d;
  logic                core_start_q, core_start_d;

  logic                asm_valid;
  logic                asm_clear;
  logic [31:0]         asm_word;
  logic                asm_done;
  logic                core_running;
  logic                tx_ready;

  assign core_running = core_start_q && !core_end;
  assign tx_ready     = !tx_busy && !tx_start_q;
  assign asm_valid    = rx_valid && ((state_q == ST_ARG) || (state_q == ST_WORD));
  assign asm_clear    = (state_q == ST_IDLE);

  io_memory_loader_byte_word_assembler u_asm (
    .clk        (clk),
    .rstn       (rstn),
    .clear      (asm_clear),
    .byte_valid (asm_valid),
    .byte_in    (rx_data),
    .word       (asm_word),
    .done       (asm_done)
  );

  assign wr_en_instr   = (state_q == ST_WRITE) && (cmd_q == OP_LOAD_INSTR);
  assign memwrite_io   = (state_q == ST_WRITE) && (cmd_q == OP_LOAD_DATA);
  assign memread_io    = (state_q == ST_RD_REQ) || (state_q == ST_RD_WAIT);
  assign addr_in_instr = {{(30-ADDR_W){1'b0}}, addr_q, 2'b00};
  assign addr_io       = {{(30-ADDR_W){1'b0}}, addr_q, 2'b00};
  assign data_in_instr = data_q;
  assign write_data_io = data_q;
  assign tx_start      = tx_start_q;
  assign tx_data       = tx_data_q;
  assign core_start    = core_start_q;
  assign error         = error_q;

  // Command decode, argument checks, word write/read sequencing and UART replies.
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    arg_idx_d    = arg_idx_q;
    base_d       = base_q;
    rem_d        = rem_q;
    addr_d       = addr_q;
    data_d       = data_q;
    byte_idx_d   = byte_idx_q;
    resp_d       = resp_q;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    error_d      = error_q;
    core_start_d = core_start_q;

    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          cmd_d     = rx_data;
          arg_idx_d = 1'b0;
          case (rx_data)
            OP_LOAD_INSTR, OP_LOAD_DATA, OP_DUMP: state_d = ST_ARG;
            OP_START: begin
              core_start_d = 1'b1;
              resp_d       = ACK_BYTE;
              state_d      = ST_ACK;
            end
            default: begin
              error_d = 1'b1;
              resp_d  = ERR_BYTE;
              state_d = ST_ACK;
            end
          endcase
        end
      end

      ST_ARG: begin
        if (asm_done) begin
          if ((cmd_q == OP_DUMP) && !arg_idx_q) begin
            base_d    = asm_word[ADDR_W+1:0];
            arg_idx_d = 1'b1;
          end else if (cmd_q == OP_DUMP) begin
            if (core_running || (base_q[1:0] != 2'b00)) begin
              error_d = 1'b1;
              resp_d  = ERR_BYTE;
              state_d = ST_ACK;
            end else if (asm_word == 32'd0) begin
              resp_d  = ACK_BYTE;
              state_d = ST_ACK;
            end else begin
              addr_d  = base_q[ADDR_W+1:2];
              rem_d   = asm_word;
              state_d = ST_RD_REQ;
            end
          end else begin
            if (core_running || (asm_word > MAX_WORDS)) begin
              error_d = 1'b1;
              resp_d  = ERR_BYTE;
              state_d = ST_ACK;
            end else if (asm_word == 32'd0) begin
              resp_d  = ACK_BYTE;
              state_d = ST_ACK;
            end else begin
              addr_d  = '0;
              rem_d   = asm_word;
              state_d = ST_WORD;
            end
          end
        end
      end

      ST_WORD: begin
        if (asm_done) begin
          data_d  = asm_word;
          state_d = ST_WRITE;
        end
      end

      ST_WRITE: begin
        addr_d = addr_q + ADDR_W'(1);
        rem_d  = rem_q - 32'd1;
        if (rem_q == 32'd1) begin
          resp_d  = ACK_BYTE;
          state_d = ST_ACK;
        end else begin
          state_d = ST_WORD;
        end
      end

      ST_RD_REQ: state_d = ST_RD_WAIT;

      ST_RD_WAIT: begin
        if (data_ready_io) begin
          data_d     = data_from_memory_io;
          byte_idx_d = 2'd0;
          state_d    = ST_TX_WORD;
        end
      end

      ST_TX_WORD: begin
        if (tx_ready) begin
          tx_start_d = 1'b1;
          tx_data_d  = data_q[{byte_idx_q, 3'b000} +: 8];
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            addr_d = addr_q + ADDR_W'(1);
            rem_d  = rem_q - 32'd1;
            if (rem_q == 32'd1) begin
              resp_d  = ACK_BYTE;
              state_d = ST_ACK;
            end else begin
              state_d = ST_RD_REQ;
            end
          end
        end
      end

      ST_ACK: begin
        if (tx_ready) begin
          tx_start_d = 1'b1;
          tx_data_d  = resp_q;
          state_d    = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (rx_valid && (state_q inside {ST_WRITE, ST_RD_REQ, ST_RD_WAIT, ST_TX_WORD, ST_ACK})) begin
      error_d = 1'b1;
    end
  end

  // State and datapath registers; reset aborts any command in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      cmd_q        <= '0;
      arg_idx_q    <= 1'b0;
      base_q       <= '0;
      rem_q        <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      byte_idx_q   <= '0;
      resp_q       <= '0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      error_q      <= 1'b0;
      core_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      arg_idx_q    <= arg_idx_d;
      base_q       <= base_d;
      rem_q        <= rem_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      byte_idx_q   <= byte_idx_d;
      resp_q       <= resp_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      error_q      <= error_d;
      core_start_q <= core_start_d;
    end
  end

endmodule
